// File: rtl/adc_packer_pkg.sv
// Shared types and header layout for the ADC frame packer.
package adc_packer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_GAP     = 2'd2
    } state_t;

    localparam int HDR_W     = 16;
    localparam int HDR_OVF   = 15;
    localparam int HDR_SW    = 14;
    localparam int HDR_SOF   = 13;
    localparam int HDR_IDX_W = 13;

    function automatic logic [HDR_W-1:0] make_header(
        input logic                 ovf,
        input logic                 sw,
        input logic                 sof,
        input logic [HDR_IDX_W-1:0] idx
    );
        logic [HDR_W-1:0] h;
        h                 = '0;
        h[HDR_OVF]        = ovf;
        h[HDR_SW]         = sw;
        h[HDR_SOF]        = sof;
        h[HDR_IDX_W-1:0]  = idx;
        return h;
    endfunction

endpackage

// File: rtl/adc_frame_packer_if.sv
// Packed-word output stream with a valid/ready handshake.
interface adc_frame_packer_if #(
    parameter int WORD_W = 64
);
    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/adc_word_fifo.sv
// Synchronous word FIFO; accepts a push while full when a pop happens in the same cycle.
module adc_word_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_addr, rd_addr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_addr];

    // NOTE: storage array has no reset; emptiness is tracked by count, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_addr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr <= '0;
            rd_addr <= '0;
            count   <= '0;
        end else begin
            if (do_push) wr_addr <= (wr_addr == AW'(DEPTH-1)) ? '0 : wr_addr + AW'(1);
            if (do_pop)  rd_addr <= (rd_addr == AW'(DEPTH-1)) ? '0 : rd_addr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (do_pop && !do_push) count <= count - (AW+1)'(1);
        end
    end
endmodule

// File: rtl/adc_frame_packer.sv
// ADC frame packer: selects a channel per sample, packs samples under a 16-bit header,
// frames words with a discard gap, drives sync pulse / polarisation switch, queues words.
module adc_frame_packer
    import adc_packer_pkg::*;
#(
    parameter int SAMPLE_W = 8,
    parameter int NCH      = 2,
    parameter int WORD_W   = 64,
    parameter int IDX_W    = 13,
    parameter int FIFO_D   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NCH*SAMPLE_W-1:0] adc_in,
    input  logic                    adc_valid,
    input  logic                    enable,
    input  logic [IDX_W-1:0]        cfg_frame_len,
    input  logic [3:0]              cfg_gap,
    input  logic [IDX_W-1:0]        cfg_pulse_off,
    input  logic [7:0]              cfg_pulse_wid,
    input  logic                    cfg_ch_auto,
    input  logic [1:0]              cfg_ch_sel,
    input  logic [23:0]             cfg_frames_to_switch,
    input  logic                    cfg_auto_pol,
    input  logic                    cfg_manual_pol,
    input  logic                    clr_ovf,
    adc_frame_packer_if.master      stream,
    output logic                    sync_pulse,
    output logic                    pol_out,
    output logic                    ovf,
    output logic [23:0]             frame_cnt
);
    localparam int PAY_W = WORD_W - HDR_W;
    localparam int SPW   = PAY_W / SAMPLE_W;
    localparam int SIW   = (SPW > 1) ? $clog2(SPW) : 1;

    state_t state, state_next;

    logic [IDX_W-1:0] sh_frame_len, sh_pulse_off;
    logic [3:0]       sh_gap;
    logic [7:0]       sh_pulse_wid;
    logic             sh_ch_auto, sh_auto_pol, sh_manual_pol;
    logic [1:0]       sh_ch_sel;
    logic [23:0]      sh_fts;

    logic [IDX_W-1:0] eff_frame_len, nxt_pulse_off;
    logic [3:0]       eff_gap;
    logic [7:0]       nxt_pulse_wid;
    logic             eff_ch_auto, eff_auto_pol, eff_manual_pol;
    logic [1:0]       eff_ch_sel;
    logic [23:0]      eff_fts, fts_eff;
    logic             in_idle, sh_load;

    logic [SIW-1:0]   samp_idx;
    logic [IDX_W-1:0] word_idx, word_idx_next;
    logic [1:0]       ch_rr, ch;
    logic [3:0]       gap_cnt;
    logic [PAY_W-1:0] payload, payload_now;
    logic [SAMPLE_W-1:0] sample;
    logic             cap_sample, word_done, last_word, gap_done, frame_end;
    logic [IDX_W:0]   pulse_end;
    logic             pulse_next;
    logic             push_pending, sw_state;
    logic [WORD_W-1:0] push_data, fifo_rd_data;
    logic             fifo_full, fifo_empty, fifo_pop, drop;
    logic [HDR_IDX_W-1:0] idx13;

    // While idle the live configuration is in force; once a frame runs the shadow copy is.
    assign in_idle = (state == ST_IDLE);

    always_comb begin
        eff_frame_len  = in_idle ? cfg_frame_len        : sh_frame_len;
        eff_gap        = in_idle ? cfg_gap              : sh_gap;
        eff_ch_auto    = in_idle ? cfg_ch_auto          : sh_ch_auto;
        eff_ch_sel     = in_idle ? cfg_ch_sel           : sh_ch_sel;
        eff_fts        = in_idle ? cfg_frames_to_switch : sh_fts;
        eff_auto_pol   = in_idle ? cfg_auto_pol         : sh_auto_pol;
        eff_manual_pol = in_idle ? cfg_manual_pol       : sh_manual_pol;
        fts_eff        = (eff_fts == 24'd0) ? 24'd1 : eff_fts;
    end

    assign pol_out = eff_auto_pol ? sw_state : eff_manual_pol;

    always_comb begin
        ch = ch_rr;
        if (!eff_ch_auto) ch = (32'(eff_ch_sel) < NCH) ? eff_ch_sel : 2'd0;
        sample = adc_in[SAMPLE_W-1:0];
        for (int c = 1; c < NCH; c++) begin
            if (ch == 2'(c)) sample = adc_in[c*SAMPLE_W +: SAMPLE_W];
        end
    end

    always_comb begin
        payload_now = payload;
        for (int k = 0; k < SPW; k++) begin
            if (samp_idx == SIW'(k)) payload_now[k*SAMPLE_W +: SAMPLE_W] = sample;
        end
    end

    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        state_next = state;
        cap_sample = adc_valid && ((in_idle && enable) || (state == ST_CAPTURE));
        word_done  = cap_sample && (samp_idx == SIW'(SPW-1));
        last_word  = word_done && (word_idx == eff_frame_len);
        gap_done   = (state == ST_GAP) && adc_valid && (gap_cnt == sh_gap - 4'd1);
        frame_end  = (last_word && (eff_gap == 4'd0)) || gap_done;
        if (cap_sample && in_idle)          state_next = ST_CAPTURE;
        if (last_word && (eff_gap != 4'd0)) state_next = ST_GAP;
        if (frame_end)                      state_next = enable ? ST_CAPTURE : ST_IDLE;
    end

    assign sh_load       = in_idle || frame_end;
    assign nxt_pulse_off = sh_load ? cfg_pulse_off : sh_pulse_off;
    assign nxt_pulse_wid = sh_load ? cfg_pulse_wid : sh_pulse_wid;

    always_comb begin
        word_idx_next = word_idx;
        if (word_done) word_idx_next = last_word ? '0 : word_idx + IDX_W'(1);
        pulse_end  = {1'b0, nxt_pulse_off} + (IDX_W+1)'(nxt_pulse_wid);
        pulse_next = (state_next == ST_CAPTURE) && (nxt_pulse_wid != 8'd0) &&
                     (word_idx_next >= nxt_pulse_off) && ({1'b0, word_idx_next} < pulse_end);
    end

    if (IDX_W >= HDR_IDX_W) begin : g_idx_trunc
        assign idx13 = word_idx[HDR_IDX_W-1:0];
    end else begin : g_idx_ext
        assign idx13 = {{(HDR_IDX_W-IDX_W){1'b0}}, word_idx};
    end

    assign fifo_pop = !fifo_empty && stream.out_ready;
    assign drop     = push_pending && fifo_full && !fifo_pop;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            sh_frame_len  <= '0;
            sh_pulse_off  <= '0;
            sh_gap        <= '0;
            sh_pulse_wid  <= '0;
            sh_ch_auto    <= 1'b0;
            sh_ch_sel     <= '0;
            sh_fts        <= '0;
            sh_auto_pol   <= 1'b0;
            sh_manual_pol <= 1'b0;
            samp_idx      <= '0;
            word_idx      <= '0;
            ch_rr         <= '0;
            gap_cnt       <= '0;
            payload       <= '0;
            push_pending  <= 1'b0;
            push_data     <= '0;
            sync_pulse    <= 1'b0;
            sw_state      <= 1'b0;
            frame_cnt     <= '0;
            ovf           <= 1'b0;
        end else begin
            state        <= state_next;
            sync_pulse   <= pulse_next;
            push_pending <= word_done;
            word_idx     <= word_idx_next;
            if (word_done)
                push_data <= {make_header(ovf, sw_state, word_idx == '0, idx13), payload_now};
            if (sh_load) begin
                sh_frame_len  <= cfg_frame_len;
                sh_pulse_off  <= cfg_pulse_off;
                sh_gap        <= cfg_gap;
                sh_pulse_wid  <= cfg_pulse_wid;
                sh_ch_auto    <= cfg_ch_auto;
                sh_ch_sel     <= cfg_ch_sel;
                sh_fts        <= cfg_frames_to_switch;
                sh_auto_pol   <= cfg_auto_pol;
                sh_manual_pol <= cfg_manual_pol;
            end
            if (cap_sample) begin
                payload  <= payload_now;
                samp_idx <= word_done ? '0 : samp_idx + SIW'(1);
                if (last_word || ch_rr == 2'(NCH-1)) ch_rr <= '0;
                else                                 ch_rr <= ch_rr + 2'd1;
            end
            if ((state == ST_GAP) && adc_valid) gap_cnt <= gap_done ? 4'd0 : gap_cnt + 4'd1;
            if (frame_end) begin
                if (({1'b0, frame_cnt} + 25'd1) >= {1'b0, fts_eff}) begin
                    frame_cnt <= '0;
                    sw_state  <= !sw_state;
                end else begin
                    frame_cnt <= frame_cnt + 24'd1;
                end
            end
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop)         ovf <= 1'b1;
            else if (clr_ovf) ovf <= 1'b0;
        end
    end

    adc_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_D)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_pending),
        .push_data (push_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign stream.out_data  = fifo_rd_data;
    assign stream.out_valid = !fifo_empty;
endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed self-checking bench for adc_frame_packer (SAMPLE_W=8, NCH=2, WORD_W=64, FIFO_D=4).
module tb_adc_frame_packer;
    localparam int SAMPLE_W = 8;
    localparam int NCH      = 2;
    localparam int WORD_W   = 64;
    localparam int IDX_W    = 13;
    localparam int FIFO_D   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] adc_in = '0;
    logic        adc_valid = 1'b0, enable = 1'b0;
    logic [12:0] cfg_frame_len = '0, cfg_pulse_off = '0;
    logic [3:0]  cfg_gap = '0;
    logic [7:0]  cfg_pulse_wid = '0;
    logic        cfg_ch_auto = 1'b1, cfg_auto_pol = 1'b0, cfg_manual_pol = 1'b0, clr_ovf = 1'b0;
    logic [1:0]  cfg_ch_sel = '0;
    logic [23:0] cfg_frames_to_switch = 24'd100;
    logic        sync_pulse, pol_out, ovf;
    logic [23:0] frame_cnt;

    adc_frame_packer_if #(.WORD_W(WORD_W)) stream ();

    adc_frame_packer #(
        .SAMPLE_W(SAMPLE_W), .NCH(NCH), .WORD_W(WORD_W), .IDX_W(IDX_W), .FIFO_D(FIFO_D)
    ) dut (
        .clk(clk), .rst_n(rst_n), .adc_in(adc_in), .adc_valid(adc_valid), .enable(enable),
        .cfg_frame_len(cfg_frame_len), .cfg_gap(cfg_gap), .cfg_pulse_off(cfg_pulse_off),
        .cfg_pulse_wid(cfg_pulse_wid), .cfg_ch_auto(cfg_ch_auto), .cfg_ch_sel(cfg_ch_sel),
        .cfg_frames_to_switch(cfg_frames_to_switch), .cfg_auto_pol(cfg_auto_pol),
        .cfg_manual_pol(cfg_manual_pol), .clr_ovf(clr_ovf), .stream(stream),
        .sync_pulse(sync_pulse), .pol_out(pol_out), .ovf(ovf), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] n = '0;
    logic [WORD_W-1:0] got_q[$];

    // Words are recorded on the falling edge before the rising edge that pops them.
    always @(negedge clk) begin
        if (rst_n && stream.out_valid && stream.out_ready) got_q.push_back(stream.out_data);
    end

    function automatic logic [15:0] hdr(input logic o, input logic s, input logic f, input int idx);
        return {o, s, f, 13'(idx)};
    endfunction

    // mode 0: channels alternate starting with ch0; 1: all ch1; 2: all ch0.
    function automatic logic [63:0] exp_word(input logic [15:0] h, input logic [7:0] n0, input int mode);
        logic [63:0] w;
        logic [7:0]  s;
        w = '0;
        w[63:48] = h;
        for (int j = 0; j < 6; j++) begin
            s = n0 + 8'(j);
            if (mode == 1 || (mode == 0 && (j % 2) == 1)) s = s | 8'h80;
            w[j*8 +: 8] = s;
        end
        return w;
    endfunction

    task automatic feed(input int count);
        for (int i = 0; i < count; i++) begin
            adc_in = {8'h80 | n, n};
            adc_valid = 1'b1;
            @(posedge clk);
            #1;
            n = n + 8'd1;
        end
        adc_valid = 1'b0;
    endtask

    task automatic idle(input int count);
        repeat (count) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        adc_valid = 1'b0; enable = 1'b0; clr_ovf = 1'b0;
        cfg_frame_len = '0; cfg_gap = '0; cfg_pulse_off = '0; cfg_pulse_wid = '0;
        cfg_ch_auto = 1'b1; cfg_ch_sel = '0; cfg_frames_to_switch = 24'd100;
        cfg_auto_pol = 1'b0; cfg_manual_pol = 1'b0;
        stream.out_ready = 1'b1;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        got_q.delete();
        n = '0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (stream.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset out_valid: got %b want 0", stream.out_valid); end
        vectors++; if (stream.out_data !== 64'h0) begin miscompares++; $display("FAIL reset out_data: got %h want 0", stream.out_data); end
        vectors++; if (sync_pulse !== 1'b0) begin miscompares++; $display("FAIL reset sync_pulse: got %b want 0", sync_pulse); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset ovf: got %b want 0", ovf); end
        vectors++; if (frame_cnt !== 24'd0) begin miscompares++; $display("FAIL reset frame_cnt: got %0d want 0", frame_cnt); end
        vectors++; if (pol_out !== 1'b0) begin miscompares++; $display("FAIL reset pol_out: got %b want 0", pol_out); end
    endtask

    task automatic test_frame();
        logic [63:0] exp [4];
        do_reset();
        exp[0] = 64'h2000_8504_8302_8100;
        exp[1] = 64'h0001_8B0A_8908_8706;
        exp[2] = 64'h0002_9110_8F0E_8D0C;
        exp[3] = 64'h2000_9817_9615_9413;
        cfg_frame_len = 13'd2; cfg_gap = 4'd1; enable = 1'b1;
        feed(25);
        idle(4);
        vectors++; if (got_q.size() !== 4) begin miscompares++; $display("FAIL frame word count: got %0d want 4", got_q.size()); end
        for (int i = 0; i < 4; i++) begin
            vectors++; if (got_q[i] !== exp[i]) begin miscompares++; $display("FAIL frame word %0d: got %h want %h", i, got_q[i], exp[i]); end
        end
        vectors++; if (frame_cnt !== 24'd1) begin miscompares++; $display("FAIL frame frame_cnt: got %0d want 1", frame_cnt); end
    endtask

    task automatic test_fixed_channel();
        logic [63:0] e0, e1;
        do_reset();
        e0 = exp_word(hdr(0, 0, 1, 0), 8'd0, 1);
        e1 = exp_word(hdr(0, 0, 1, 0), 8'd6, 2);
        cfg_ch_auto = 1'b0; cfg_ch_sel = 2'd1; enable = 1'b1;
        feed(2);
        cfg_ch_sel = 2'd3;
        feed(10);
        idle(4);
        vectors++; if (got_q[0] !== e0) begin miscompares++; $display("FAIL fixed ch1 word: got %h want %h", got_q[0], e0); end
        vectors++; if (got_q[1] !== e1) begin miscompares++; $display("FAIL fixed ch_sel3 word: got %h want %h", got_q[1], e1); end
    endtask

    task automatic test_pol();
        logic [23:0] ec;
        logic        ep;
        do_reset();
        cfg_frames_to_switch = 24'd3; cfg_auto_pol = 1'b1; enable = 1'b1;
        for (int f = 1; f <= 9; f++) begin
            feed(6);
            ec = 24'(f % 3);
            ep = 1'((f / 3) % 2);
            vectors++; if (frame_cnt !== ec) begin miscompares++; $display("FAIL pol frame_cnt after frame %0d: got %0d want %0d", f, frame_cnt, ec); end
            vectors++; if (pol_out !== ep) begin miscompares++; $display("FAIL pol pol_out after frame %0d: got %b want %b", f, pol_out, ep); end
        end
    endtask

    task automatic test_pulse(input logic [7:0] wid);
        int   idx;
        logic ep;
        do_reset();
        cfg_frame_len = 13'd20; cfg_pulse_off = 13'd5; cfg_pulse_wid = wid; enable = 1'b1;
        for (int t = 1; t <= 126; t++) begin
            feed(1);
            idx = (t / 6) % 21;
            ep = (wid != 8'd0) && (idx >= 5) && (idx <= 7);
            vectors++; if (sync_pulse !== ep) begin miscompares++; $display("FAIL pulse wid %0d sample %0d: got %b want %b", wid, t, sync_pulse, ep); end
        end
    endtask

    task automatic test_overflow();
        logic [63:0] e;
        do_reset();
        stream.out_ready = 1'b0;
        cfg_frame_len = 13'd20; enable = 1'b1;
        feed(24);
        idle(1);
        vectors++; if (stream.out_valid !== 1'b1) begin miscompares++; $display("FAIL ovf out_valid held: got %b want 1", stream.out_valid); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL ovf before drop: got %b want 0", ovf); end
        feed(6);
        idle(1);
        vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL ovf after drop: got %b want 1", ovf); end
        feed(6);
        idle(1);
        stream.out_ready = 1'b1;
        idle(6);
        vectors++; if (got_q.size() !== 4) begin miscompares++; $display("FAIL ovf held words: got %0d want 4", got_q.size()); end
        for (int i = 0; i < 4; i++) begin
            e = exp_word(hdr(0, 0, i == 0, i), 8'(6 * i), 0);
            vectors++; if (got_q[i] !== e) begin miscompares++; $display("FAIL ovf held word %0d: got %h want %h", i, got_q[i], e); end
        end
        feed(6);
        idle(3);
        e = exp_word(hdr(1, 0, 0, 6), 8'd36, 0);
        vectors++; if (got_q[4] !== e) begin miscompares++; $display("FAIL ovf header word: got %h want %h", got_q[4], e); end
        clr_ovf = 1'b1;
        idle(1);
        clr_ovf = 1'b0;
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL ovf clear: got %b want 0", ovf); end
        feed(6);
        idle(3);
        e = exp_word(hdr(0, 0, 0, 7), 8'd42, 0);
        vectors++; if (got_q[5] !== e) begin miscompares++; $display("FAIL ovf cleared word: got %h want %h", got_q[5], e); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] e;
        do_reset();
        stream.out_ready = 1'b0;
        cfg_frame_len = 13'd20; cfg_pulse_off = 13'd2; cfg_pulse_wid = 8'd10; enable = 1'b1;
        feed(33);
        vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL mid-reset pre ovf: got %b want 1", ovf); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (stream.out_valid !== 1'b0) begin miscompares++; $display("FAIL mid-reset out_valid: got %b want 0", stream.out_valid); end
        vectors++; if (stream.out_data !== 64'h0) begin miscompares++; $display("FAIL mid-reset out_data: got %h want 0", stream.out_data); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL mid-reset ovf: got %b want 0", ovf); end
        vectors++; if (sync_pulse !== 1'b0) begin miscompares++; $display("FAIL mid-reset sync_pulse: got %b want 0", sync_pulse); end
        vectors++; if (frame_cnt !== 24'd0) begin miscompares++; $display("FAIL mid-reset frame_cnt: got %0d want 0", frame_cnt); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        got_q.delete();
        n = 8'd100;
        cfg_pulse_wid = 8'd0;
        stream.out_ready = 1'b1;
        feed(6);
        idle(3);
        e = exp_word(hdr(0, 0, 1, 0), 8'd100, 0);
        vectors++; if (got_q.size() !== 1) begin miscompares++; $display("FAIL post-reset word count: got %0d want 1", got_q.size()); end
        vectors++; if (got_q[0] !== e) begin miscompares++; $display("FAIL post-reset word: got %h want %h", got_q[0], e); end
    endtask

    task automatic test_midframe_cfg();
        logic [15:0] eh;
        do_reset();
        cfg_frame_len = 13'd1; enable = 1'b1;
        feed(3);
        cfg_frame_len = 13'd5;
        enable = 1'b0;
        feed(9);
        feed(6);
        idle(3);
        vectors++; if (got_q.size() !== 2) begin miscompares++; $display("FAIL midcfg word count: got %0d want 2", got_q.size()); end
        vectors++; if (got_q[0][63:48] !== hdr(0, 0, 1, 0)) begin miscompares++; $display("FAIL midcfg header 0: got %h want %h", got_q[0][63:48], hdr(0, 0, 1, 0)); end
        vectors++; if (got_q[1][63:48] !== hdr(0, 0, 0, 1)) begin miscompares++; $display("FAIL midcfg header 1: got %h want %h", got_q[1][63:48], hdr(0, 0, 0, 1)); end
        vectors++; if (frame_cnt !== 24'd1) begin miscompares++; $display("FAIL midcfg frame_cnt: got %0d want 1", frame_cnt); end
        got_q.delete();
        enable = 1'b1;
        feed(42);
        idle(3);
        vectors++; if (got_q.size() !== 7) begin miscompares++; $display("FAIL midcfg new length count: got %0d want 7", got_q.size()); end
        for (int i = 0; i < 7; i++) begin
            eh = hdr(0, 0, (i % 6) == 0, i % 6);
            vectors++; if (got_q[i][63:48] !== eh) begin miscompares++; $display("FAIL midcfg new header %0d: got %h want %h", i, got_q[i][63:48], eh); end
        end
    endtask

    initial begin
        stream.out_ready = 1'b1;
        test_reset();
        test_frame();
        test_fixed_channel();
        test_pol();
        test_pulse(8'd3);
        test_pulse(8'd0);
        test_overflow();
        test_reset_mid();
        test_midframe_cfg();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/adc_frame_packer.md
ADC_FRAME_PACKER -- requirements
Module: adc_frame_packer

Interface
REQ-001 Parameters, one per line: name, default, meaning:
  SAMPLE_W  8   ADC sample width, bits
  NCH       2   number of ADC channels, 1..4
  WORD_W    64  output word width; WORD_W-16 is a multiple of SAMPLE_W
  IDX_W     13  word-index counter width
  FIFO_D    4   output FIFO depth, power of 2
REQ-002 Ports, one per line: name, direction, width, meaning:
  clk  in  1  single system clock
  rst_n  in  1  reset; asynchronous, active-low
  adc_in  in  NCH*SAMPLE_W  channel c at bits [c*SAMPLE_W +: SAMPLE_W]
  adc_valid  in  1  one sample set per strobe
  enable  in  1  capture enable
  cfg_frame_len  in  IDX_W  last word index of a frame; frame = cfg_frame_len+1 words
  cfg_gap  in  4  samples discarded between frames (noise guard)
  cfg_pulse_off  in  IDX_W  sync pulse start word index
  cfg_pulse_wid  in  8  sync pulse width in words; 0 means no pulse
  cfg_ch_auto  in  1  1 = round-robin channels; 0 = fixed channel
  cfg_ch_sel  in  2  fixed channel index
  cfg_frames_to_switch  in  24  frames per polarisation-switch period
  cfg_auto_pol / cfg_manual_pol  in  1 / 1  switcher source select / manual level
  clr_ovf  in  1  clears ovf
  out_data  out  WORD_W  packed word
  out_valid / out_ready  out / in  1 / 1  valid/ready handshake
  sync_pulse  out  1  optical start pulse
  pol_out  out  1  switcher output
  ovf  out  1  sticky word-dropped flag
  frame_cnt  out  24  frames since last polarisation toggle

Function
REQ-003 SPW = (WORD_W-16)/SAMPLE_W samples per word; sample k of a word at bits [k*SAMPLE_W +: SAMPLE_W], k=0 first-received.
REQ-004 Header bits [WORD_W-1 -: 16] = {ovf, sw_state, sof, word_idx[12:0]}; sof=1 only on word_idx 0; for IDX_W<13 zero-extend, for IDX_W>13 take LSBs.
REQ-005 Channel per accepted sample: cfg_ch_auto ? (sample_cnt mod NCH) : cfg_ch_sel; sample_cnt restarts at 0 each frame; cfg_ch_sel >= NCH selects channel 0.
REQ-006 FSM states IDLE, CAPTURE, GAP; samples are counted only on adc_valid=1.
REQ-007 IDLE -> CAPTURE on first adc_valid with enable=1; that sample is word 0, sample 0.
REQ-008 CAPTURE: on completion of word cfg_frame_len go to GAP (cfg_gap>0) or end frame directly (cfg_gap=0).
REQ-009 GAP: discard cfg_gap valid samples, then end frame.
REQ-010 Frame end: next state CAPTURE if enable=1, else IDLE; enable deassertion mid-frame takes effect only at frame end.
REQ-011 All cfg_* except clr_ovf are shadowed at IDLE->CAPTURE and at each frame end; mid-frame cfg changes have no effect.
REQ-012 Completed word enters FIFO the clock after its last sample; if FIFO full the word is dropped and ovf set.
REQ-013 ovf clears on clr_ovf=1; a simultaneous drop wins (ovf stays 1).
REQ-014 out_valid = FIFO non-empty; a word pops on out_valid & out_ready; push and pop in one cycle on a full FIFO succeed with no drop.
REQ-015 Frame end: if frame_cnt+1 >= cfg_frames_to_switch then frame_cnt<=0 and sw_state toggles, else frame_cnt increments; value 0 behaves as 1.
REQ-016 pol_out = cfg_auto_pol ? sw_state : cfg_manual_pol (combinational).
REQ-017 sync_pulse registered: set when the CAPTURE word index becomes cfg_pulse_off, cleared when it reaches cfg_pulse_off+cfg_pulse_wid (IDX_W+1-bit sum) or when leaving CAPTURE; never set if cfg_pulse_wid=0.

Reset
REQ-018 rst_n low: FSM IDLE, all counters 0, FIFO empty, out_valid 0, out_data 0, sync_pulse 0, sw_state 0, ovf 0, frame_cnt 0; a partial word is discarded.
REQ-019 Reset has immediate effect; the first capture begins on the first adc_valid with enable=1 after rst_n rises.

Structure
REQ-020 Package adc_packer_pkg holds the FSM state enum, header width 16 and header field offsets.
REQ-021 Output FIFO is sub-module adc_word_fifo (WIDTH, DEPTH; push, pop, full, empty); everything else is in one module.

Verification
REQ-022 NCH=2, auto, frame_len=2, gap=1, ramp 0x00.. -> 3 words, samples alternate channels, idx 0,1,2, sof only on word 0, 1 sample skipped, next frame idx 0.
REQ-023 frames_to_switch=3, auto_pol=1 -> pol_out toggles after frames 3, 6, 9; frame_cnt cycles 0,1,2.
REQ-024 pulse_off=5, wid=3, frame_len=20 -> sync_pulse high from word 5 through word 7, low from word 8; wid=0 -> never high.
REQ-025 out_ready=0 for 6 words, FIFO_D=4 -> 4 words held, 2 dropped, ovf=1 and seen in header of subsequent words; clr_ovf -> 0.
REQ-026 rst_n low mid-word, then high -> outputs at reset values, first word after release has idx 0 and contains only post-reset samples.
REQ-027 cfg_frame_len changed mid-frame and enable dropped mid-frame -> current frame completes with old length, FSM then IDLE.
